// File: rtl/ori_hist_peak.sv
// ori_hist_peak: 16-bin orientation histogram with dominant-direction search.
// Samples accumulate (saturating) into bins until a sample marked in_last is
// accepted.  A 16-cycle scan then finds the strongest bin, lowest index
// winning ties.  The result is held until the downstream handshake, which
// also clears the histogram for the next keypoint window.
// Optional build macro ORI_HIST_SMOOTH_EN: the scan compares the circularly
// smoothed value (h[i-1] + 2*h[i] + h[i+1]) >> 2 instead of the raw bin.
module ori_hist_peak #(
    parameter int MAG_W = 16,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_bin,
    input  logic [MAG_W-1:0] in_mag,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_dir,
    output logic [ACC_W-1:0] out_peak
);

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] hist [16];
    logic [3:0]       scan_cnt;
    logic [ACC_W-1:0] max_val;
    logic [3:0]       max_idx;

    logic [ACC_W-1:0] cand_val;
    logic             cand_gt;

    // Bin accumulate clamped to the all-ones accumulator value.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [MAG_W-1:0] b);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + (ACC_W+1)'(b);
        sat_add = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    endfunction

    assign in_ready = (state == ACC);

`ifdef ORI_HIST_SMOOTH_EN
    logic [3:0]       prev_idx;
    logic [3:0]       next_idx;
    logic [ACC_W+1:0] smooth_sum;

    // Smoothed value of the bin under scan; 4-bit indices wrap modulo 16.
    always_comb begin
        prev_idx   = scan_cnt - 4'd1;
        next_idx   = scan_cnt + 4'd1;
        smooth_sum = (ACC_W+2)'(hist[prev_idx])
                   + {1'b0, hist[scan_cnt], 1'b0}
                   + (ACC_W+2)'(hist[next_idx]);
        cand_val   = smooth_sum[ACC_W+1:2];
    end
`else
    // Raw bin value under scan.
    always_comb begin
        cand_val = hist[scan_cnt];
    end
`endif

    assign cand_gt = (cand_val > max_val);

    // Control FSM, histogram storage and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            for (int i = 0; i < 16; i++) hist[i] <= '0;
            scan_cnt  <= '0;
            max_val   <= '0;
            max_idx   <= '0;
            out_valid <= 1'b0;
            out_dir   <= '0;
            out_peak  <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (in_valid) begin
                        hist[in_bin] <= sat_add(hist[in_bin], in_mag);
                        if (in_last) begin
                            state    <= SCAN;
                            scan_cnt <= '0;
                            max_val  <= '0;
                            max_idx  <= '0;
                        end
                    end
                end
                SCAN: begin
                    scan_cnt <= scan_cnt + 4'd1;
                    if (cand_gt) begin
                        max_val <= cand_val;
                        max_idx <= scan_cnt;
                    end
                    // Last bin folds straight into the registered result.
                    if (scan_cnt == 4'd15) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        out_dir   <= cand_gt ? scan_cnt : max_idx;
                        out_peak  <= cand_gt ? cand_val : max_val;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        for (int i = 0; i < 16; i++) hist[i] <= '0;
                        out_valid <= 1'b0;
                        state     <= ACC;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

endmodule

// File: doc/ori_hist_peak.md
ORI_HIST_PEAK -- requirements
Module: ori_hist_peak

Interface
REQ-001 Parameter MAG_W, default 16: width of the unsigned gradient magnitude input.
REQ-002 Parameter ACC_W, default 24: width of each unsigned histogram bin accumulator; ACC_W SHALL be at least MAG_W+1.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  the input sample is valid.
REQ-006 in_ready  output  1  the block accepts a sample this cycle.
REQ-007 in_bin  input  4  gradient orientation bin, 0..15.
REQ-008 in_mag  input  MAG_W  gradient magnitude, unsigned.
REQ-009 in_last  input  1  this sample closes the current keypoint window.
REQ-010 out_valid  output  1  the dominant-direction result is valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_dir  output  4  dominant bin index; it feeds the low nibble of the direction-offset ROM address.
REQ-013 out_peak  output  ACC_W  accumulated (or smoothed) value of the dominant bin.

Function
REQ-014 The block SHALL use a state machine with states ACC, SCAN and OUT; reset SHALL enter ACC.
REQ-015 In ACC, in_ready SHALL be 1; in SCAN and OUT, in_ready SHALL be 0.
REQ-016 A sample is accepted when in_valid and in_ready are both 1; acceptance adds in_mag to hist[in_bin].
REQ-017 Bin addition SHALL saturate at 2^ACC_W-1; it SHALL never wrap.
REQ-018 Accepting a sample with in_last=1 SHALL include that sample and move the state to SCAN on the next cycle.
REQ-019 SCAN SHALL last exactly 16 cycles and examine bins 0..15 in ascending order, one bin per cycle.
REQ-020 Max tracking SHALL use a strict greater-than compare, so on a tie the lowest bin index wins.
REQ-021 If in_last is accepted at cycle T, out_valid SHALL rise at cycle T+17.
REQ-022 In OUT, out_valid, out_dir and out_peak SHALL stay stable until out_ready=1.
REQ-023 If out_valid and out_ready are both 1, in the next cycle:
  - all 16 bins SHALL be cleared;
  - out_valid SHALL be 0;
  - the state SHALL return to ACC, with in_ready=1.
REQ-024 An all-zero histogram SHALL give out_dir=0 and out_peak=0.
REQ-025 in_valid while in_ready=0 SHALL be ignored; no bin SHALL change.
REQ-026 in_bin and in_mag SHALL be ignored when in_valid=0.
REQ-027 Back-to-back windows are allowed: a new window's first sample may be accepted in the first ACC cycle after the handshake.

Reset
REQ-028 While rst=1, on each clock edge:
  - state SHALL be ACC;
  - all bins SHALL be 0;
  - out_valid SHALL be 0, out_dir 0, out_peak 0;
  - the scan counter and max registers SHALL be 0.
REQ-029 When reset is released, in_ready SHALL be 1 on the first cycle.
REQ-030 Reset asserted during SCAN or OUT SHALL abandon the window; no result SHALL be emitted for it.

Configuration
REQ-031 Macro ORI_HIST_SMOOTH_EN, when defined:
  - SCAN SHALL compare the smoothed value s[i] = (hist[i-1] + 2*hist[i] + hist[i+1]) >> 2, with bin indices taken modulo 16;
  - the sum SHALL be computed at ACC_W+2 bits;
  - out_peak SHALL be s[out_dir];
  - latency SHALL be unchanged.
REQ-032 When ORI_HIST_SMOOTH_EN is not defined, SCAN SHALL compare raw hist[i], and out_peak SHALL be hist[out_dir].

Verification
REQ-033 Raw build: samples (bin 3, mag 100), (bin 7, mag 50), (bin 3, mag 20, last) -> out_dir=3 and out_peak=120, with out_valid at 17 cycles after the last sample.
REQ-034 Tie: (bin 9, mag 40), (bin 2, mag 40, last) -> out_dir=2, out_peak=40.
REQ-035 Saturation, with MAG_W=16 and ACC_W=17: three samples (bin 5, mag 0xFFFF), the last with in_last -> out_peak=0x1FFFF.
REQ-036 Backpressure: hold out_ready=0 for 10 cycles -> outputs stable and in_ready=0 throughout; in_valid pulses in that time are ignored; the next window result excludes them.
REQ-037 Smoothing build: hist[15]=40, hist[0]=80, hist[1]=0, all other bins 0 ->
  - s[0] = (40+160+0) >> 2 = 50;
  - s[15] = (0+80+80) >> 2 = 40;
  - result: out_dir=0, out_peak=50 (wrap-around check).
REQ-038 Reset during SCAN, then a new window of a single sample (bin 12, mag 7, last) -> out_dir=12, out_peak=7, with no stale bins.
